// File: rtl/wash_phase_timer_pkg.sv
// ----------------------------------------------------------------------------
// wm_pkg
// Encodings shared by the Microcontroller FSM and the wash_phase_timer.
//   - STATE_W and the controller state codes (IDLE..SPIN; codes 6-7 unused)
//   - phase_t : internal timer phase (untimed / counting / expired)
//   - is_timed() : 1 for the phases that carry a duration
//   - dur_sel()  : maps a timed state code to its duration-select index
// ----------------------------------------------------------------------------
package wm_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] READY = 3'd1;
  localparam logic [STATE_W-1:0] SOAK  = 3'd2;
  localparam logic [STATE_W-1:0] WASH  = 3'd3;
  localparam logic [STATE_W-1:0] RINSE = 3'd4;
  localparam logic [STATE_W-1:0] SPIN  = 3'd5;

  typedef enum logic [1:0] {
    PH_UNTIMED = 2'd0,
    PH_COUNT   = 2'd1,
    PH_EXPIRED = 2'd2
  } phase_t;

  function automatic logic is_timed(input logic [STATE_W-1:0] s);
    return (s == SOAK) || (s == WASH) || (s == RINSE) || (s == SPIN);
  endfunction

  // Index 0..3 = SOAK, WASH, RINSE, SPIN; untimed codes return 0 but are
  // never used to load the counter.
  function automatic logic [1:0] dur_sel(input logic [STATE_W-1:0] s);
    logic [1:0] sel;
    case (s)
      SOAK:    sel = 2'd0;
      WASH:    sel = 2'd1;
      RINSE:   sel = 2'd2;
      SPIN:    sel = 2'd3;
      default: sel = 2'd0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/wash_phase_timer_if.sv
// ----------------------------------------------------------------------------
// wash_phase_timer_if
// Signals exchanged between the controller side and the phase timer.
//   state          : controller state code (controller -> timer)
//   sig_Lid_Closed : 1 = lid closed, 0 pauses timing (controller -> timer)
//   sig_Time_Out   : one-cycle phase-expired pulse (timer -> controller)
//   remaining      : ticks left in current phase (timer -> controller)
//   running        : timed phase actively counting (timer -> controller)
// Modports: master = controller side, slave = timer side.
// ----------------------------------------------------------------------------
interface wash_phase_timer_if
  import wm_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic [STATE_W-1:0] state;
  logic               sig_Lid_Closed;
  logic               sig_Time_Out;
  logic [CNT_W-1:0]   remaining;
  logic               running;

  modport master (
    output state,
    output sig_Lid_Closed,
    input  sig_Time_Out,
    input  remaining,
    input  running
  );

  modport slave (
    input  state,
    input  sig_Lid_Closed,
    output sig_Time_Out,
    output remaining,
    output running
  );

endinterface

// File: rtl/wash_phase_timer_tick_prescaler.sv
// ----------------------------------------------------------------------------
// tick_prescaler
// Divides the clock into timer ticks. Counts 0..TICK_DIV-1 while enabled and
// holds its value while disabled; tick is high during the cycle whose rising
// edge wraps the count back to 0.
//   clock  : system clock, rising edge
//   reset  : asynchronous, active-high
//   clear  : synchronous restart of the count (overrides enable, no tick)
//   enable : advance the count this cycle
//   tick   : one-cycle tick pulse (combinational from count/enable/clear)
// ----------------------------------------------------------------------------
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int          PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt;

  assign tick = enable && !clear && (cnt == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + PW'(1);
    end
  end

endmodule

// File: rtl/wash_phase_timer.sv
// ----------------------------------------------------------------------------
// wash_phase_timer
// Times each washing-machine phase for the Microcontroller FSM. On entry to a
// timed phase (SOAK/WASH/RINSE/SPIN) the phase duration is loaded and counted
// down in prescaled ticks, pausing while the lid is open. The tick that takes
// the count from 1 to 0 raises sig_Time_Out for one cycle.
//   clock : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : wash_phase_timer_if.slave
//           in : state, sig_Lid_Closed
//           out: sig_Time_Out, remaining, running
// ----------------------------------------------------------------------------
module wash_phase_timer
  import wm_pkg::*;
#(
  parameter int TICK_DIV    = 4,
  parameter int CNT_W       = 16,
  parameter int SOAK_TICKS  = 3,
  parameter int WASH_TICKS  = 5,
  parameter int RINSE_TICKS = 4,
  parameter int SPIN_TICKS  = 6
) (
  input  logic               clock,
  input  logic               reset,
  wash_phase_timer_if.slave  bus
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // A zero duration would never expire, so it is stretched to one tick.
  function automatic logic [CNT_W-1:0] phase_duration(input logic [1:0] sel);
    logic [CNT_W-1:0] d;
    case (sel)
      2'd0:    d = CNT_W'(SOAK_TICKS);
      2'd1:    d = CNT_W'(WASH_TICKS);
      2'd2:    d = CNT_W'(RINSE_TICKS);
      default: d = CNT_W'(SPIN_TICKS);
    endcase
    if (d == '0) d = ONE;
    return d;
  endfunction

  logic [STATE_W-1:0] prev_state;
  phase_t             phase_q, phase_nxt;
  logic [CNT_W-1:0]   remaining_q, remaining_nxt;
  logic               pulse_q, pulse_nxt;
  logic               entry;
  logic               tick;

  assign entry = (bus.state != prev_state);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .clear  (entry),
    .enable ((phase_q == PH_COUNT) && bus.sig_Lid_Closed),
    .tick   (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_state  <= IDLE;
      phase_q     <= PH_UNTIMED;
      remaining_q <= '0;
      pulse_q     <= 1'b0;
    end else begin
      prev_state  <= bus.state;
      phase_q     <= phase_nxt;
      remaining_q <= remaining_nxt;
      pulse_q     <= pulse_nxt;
    end
  end

  // Entry takes priority over a coincident expiry tick: the counter reloads
  // and the pulse is suppressed.
  always_comb begin
    phase_nxt     = phase_q;
    remaining_nxt = remaining_q;
    pulse_nxt     = 1'b0;
    if (entry) begin
      if (is_timed(bus.state)) begin
        phase_nxt     = PH_COUNT;
        remaining_nxt = phase_duration(dur_sel(bus.state));
      end else begin
        phase_nxt     = PH_UNTIMED;
        remaining_nxt = '0;
      end
    end else if (tick && (phase_q == PH_COUNT) && (remaining_q != '0)) begin
      remaining_nxt = remaining_q - ONE;
      if (remaining_q == ONE) begin
        pulse_nxt = 1'b1;
        phase_nxt = PH_EXPIRED;
      end
    end
  end

  assign bus.sig_Time_Out = pulse_q;
  assign bus.remaining    = remaining_q;
  assign bus.running      = (phase_q == PH_COUNT);

endmodule
